// File: rtl/cache_set_array.sv
// cache_set_array: N-way set-associative tag/data/LRU storage with a one-stage request pipeline
// and hardware init/flush sweeps (the arrays themselves are never reset).
module cache_set_array #(
  parameter int INDEX_BIT        = 10,
  parameter int NUMBER_OF_SETS   = 1000,
  parameter int TAG_BIT          = 20,
  parameter int NUM_WAYS         = 2,
  parameter int BLOCK_SIZE_WORDS = 4,
  localparam int WAY_BIT         = $clog2(NUM_WAYS),
  localparam int LINE_W          = 32 * BLOCK_SIZE_WORDS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [INDEX_BIT-1:0] req_index,
  input  logic [TAG_BIT-1:0]   req_tag,
  input  logic [WAY_BIT-1:0]   req_way,
  input  logic [LINE_W-1:0]    req_data,
  input  logic                 req_dirty,
  input  logic                 flush_req,
  output logic                 busy,
  output logic                 sweep_done,
  output logic                 rsp_valid,
  output logic                 rsp_hit,
  output logic [WAY_BIT-1:0]   rsp_way,
  output logic                 rsp_line_valid,
  output logic                 rsp_dirty,
  output logic [TAG_BIT-1:0]   rsp_tag,
  output logic [LINE_W-1:0]    rsp_data
);
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_FLUSH} state_t;
  localparam logic [1:0] OP_LOOKUP = 2'd0, OP_FILL = 2'd1, OP_WRITE = 2'd2, OP_INV = 2'd3;
  typedef logic [NUM_WAYS-1:0][WAY_BIT-1:0] ages_t;
  state_t                 r_state;
  logic [INDEX_BIT-1:0]   r_cnt;
  logic                   r_stg_v;
  logic [1:0]             r_stg_op;
  logic [INDEX_BIT-1:0]   r_stg_idx;
  logic [TAG_BIT-1:0]     r_stg_tag;
  logic [WAY_BIT-1:0]     r_stg_way;
  logic [LINE_W-1:0]      r_stg_data;
  logic                   r_stg_dirty;
  logic                   r_h_hit;
  logic [WAY_BIT-1:0]     r_h_way;
  logic                   r_h_lv;
  logic                   r_h_dirty;
  logic [TAG_BIT-1:0]     r_h_tag;
  logic [LINE_W-1:0]      r_h_data;
  logic [NUM_WAYS-1:0]    r_valid [NUMBER_OF_SETS];
  logic [NUM_WAYS-1:0]    r_dirty [NUMBER_OF_SETS];
  ages_t                  r_age   [NUMBER_OF_SETS];
  logic [TAG_BIT-1:0]     r_tag   [NUMBER_OF_SETS][NUM_WAYS];
  logic [LINE_W-1:0]      r_data  [NUMBER_OF_SETS][NUM_WAYS];
  logic                   w_accept;
  logic                   w_sweep;
  logic                   w_last;
  logic [NUM_WAYS-1:0]    w_vld;
  logic [NUM_WAYS-1:0]    w_drt;
  ages_t                  w_ages;
  ages_t                  w_ages_mru;
  ages_t                  w_age_init;
  logic                   w_hit;
  logic [WAY_BIT-1:0]     w_hit_way;
  logic                   w_inv_any;
  logic [WAY_BIT-1:0]     w_inv_way;
  logic [WAY_BIT-1:0]     w_lru_way;
  logic [WAY_BIT-1:0]     w_sel_way;
  logic                   w_mru;
  logic [NUM_WAYS-1:0]    w_vld_nxt;
  logic [NUM_WAYS-1:0]    w_drt_nxt;
  logic [INDEX_BIT-1:0]   w_widx;
  logic                   w_rsp_hit;
  assign req_ready  = (r_state == S_IDLE) & ~flush_req;
  assign busy       = r_state != S_IDLE;
  assign w_sweep    = busy;
  assign w_last     = r_cnt == INDEX_BIT'(NUMBER_OF_SETS - 1);
  assign sweep_done = w_sweep & w_last;
  assign w_accept   = req_valid & req_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else if (w_sweep) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) r_state <= S_IDLE;
    end else if (flush_req) begin
      r_state <= S_FLUSH;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_v     <= 1'b0;
      r_stg_op    <= '0;
      r_stg_idx   <= '0;
      r_stg_tag   <= '0;
      r_stg_way   <= '0;
      r_stg_data  <= '0;
      r_stg_dirty <= 1'b0;
    end else begin
      r_stg_v <= w_accept;
      if (w_accept) begin
        r_stg_op    <= req_op;
        r_stg_idx   <= INDEX_BIT'(32'(req_index) % NUMBER_OF_SETS);
        r_stg_tag   <= req_tag;
        r_stg_way   <= req_way;
        r_stg_data  <= req_data;
        r_stg_dirty <= req_dirty;
      end
    end
  end
  assign w_vld  = r_valid[r_stg_idx];
  assign w_drt  = r_dirty[r_stg_idx];
  assign w_ages = r_age[r_stg_idx];
  // Descending scan so the lowest matching / invalid way is the one left standing.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_inv_any = 1'b0;
    w_inv_way = '0;
    w_lru_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (w_vld[w] && r_tag[r_stg_idx][w] == r_stg_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_BIT'(w);
      end
      if (!w_vld[w]) begin
        w_inv_any = 1'b1;
        w_inv_way = WAY_BIT'(w);
      end
      if (w_ages[w] == WAY_BIT'(NUM_WAYS - 1)) w_lru_way = WAY_BIT'(w);
    end
  end
  assign w_sel_way = r_stg_op != OP_LOOKUP ? r_stg_way :
                     w_hit ? w_hit_way : w_inv_any ? w_inv_way : w_lru_way;
  assign w_rsp_hit = (r_stg_op == OP_LOOKUP) & w_hit;
  assign w_mru     = (r_stg_op == OP_FILL) | (r_stg_op == OP_WRITE) | w_rsp_hit;
  always_comb begin
    w_ages_mru = w_ages;
    w_age_init = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      w_age_init[w] = WAY_BIT'(w);
      w_ages_mru[w] = WAY_BIT'(w) == w_sel_way ? '0 :
                      w_ages[w] < w_ages[w_sel_way] ? w_ages[w] + 1'b1 : w_ages[w];
    end
  end
  always_comb begin
    w_vld_nxt = w_vld;
    w_drt_nxt = w_drt;
    w_vld_nxt[r_stg_way] = r_stg_op == OP_FILL ? 1'b1 : r_stg_op == OP_INV ? 1'b0 : w_vld[r_stg_way];
    w_drt_nxt[r_stg_way] = r_stg_op == OP_FILL ? r_stg_dirty : r_stg_op == OP_WRITE ? 1'b1 :
                           r_stg_op == OP_INV ? 1'b0 : w_drt[r_stg_way];
  end
  assign w_widx = w_sweep ? r_cnt : r_stg_idx;
  always_ff @(posedge clk) begin
    if (w_sweep | r_stg_v) begin
      r_valid[w_widx] <= w_sweep ? '0 : w_vld_nxt;
      r_dirty[w_widx] <= w_sweep ? '0 : w_drt_nxt;
      r_age[w_widx]   <= w_sweep ? w_age_init : w_mru ? w_ages_mru : w_ages;
    end
    if (!w_sweep && r_stg_v && r_stg_op == OP_FILL) r_tag[r_stg_idx][r_stg_way] <= r_stg_tag;
    if (!w_sweep && r_stg_v && (r_stg_op == OP_FILL || r_stg_op == OP_WRITE))
      r_data[r_stg_idx][r_stg_way] <= r_stg_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_hit   <= 1'b0;
      r_h_way   <= '0;
      r_h_lv    <= 1'b0;
      r_h_dirty <= 1'b0;
      r_h_tag   <= '0;
      r_h_data  <= '0;
    end else if (r_stg_v) begin
      r_h_hit   <= w_rsp_hit;
      r_h_way   <= w_sel_way;
      r_h_lv    <= w_vld[w_sel_way];
      r_h_dirty <= w_drt[w_sel_way];
      r_h_tag   <= r_tag[r_stg_idx][w_sel_way];
      r_h_data  <= r_data[r_stg_idx][w_sel_way];
    end
  end
  assign rsp_valid      = r_stg_v;
  assign rsp_hit        = r_stg_v ? w_rsp_hit : r_h_hit;
  assign rsp_way        = r_stg_v ? w_sel_way : r_h_way;
  assign rsp_line_valid = r_stg_v ? w_vld[w_sel_way] : r_h_lv;
  assign rsp_dirty      = r_stg_v ? w_drt[w_sel_way] : r_h_dirty;
  assign rsp_tag        = r_stg_v ? r_tag[r_stg_idx][w_sel_way] : r_h_tag;
  assign rsp_data       = r_stg_v ? r_data[r_stg_idx][w_sel_way] : r_h_data;
endmodule

// File: doc/cache_set_array.md
# cache_set_array

Parametrised N-way set-associative storage for the cache: per-set tag/valid/dirty state, line data, true-LRU ages, hit detection and victim selection behind a single one-stage request pipeline. It replaces the fixed 2-way, 23-bit-tag data/tag RAM pair. It sits between the cache controller FSM, which issues lookups, fills, writes and invalidates, and the main-memory interface. It adds hardware initialisation and flush sweeps, since the arrays themselves are not reset.

## Interface
- INDEX_BIT, 10, set index width
- NUMBER_OF_SETS, 1000, implemented sets, ≤ 2^INDEX_BIT
- TAG_BIT, 20, stored tag width
- NUM_WAYS, 2, associativity, one of 2/4/8; WAY_BIT = log2(NUM_WAYS)
- BLOCK_SIZE_WORDS, 4, line size; LINE_W = 32*BLOCK_SIZE_WORDS
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_op  in  2  0 LOOKUP, 1 FILL, 2 WRITE, 3 INVALIDATE
- req_index  in  INDEX_BIT  set index, reduced modulo NUMBER_OF_SETS
- req_tag  in  TAG_BIT  lookup/fill tag
- req_way  in  WAY_BIT  target way for FILL/WRITE/INVALIDATE
- req_data  in  LINE_W  line for FILL/WRITE
- req_dirty  in  1  dirty value written by FILL
- flush_req  in  1  start invalidate-all sweep
- busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse at end of any sweep
- rsp_valid  out  1  response for request accepted the previous cycle
- rsp_hit  out  1  LOOKUP hit
- rsp_way  out  WAY_BIT  hit way, victim way, or req_way
- rsp_line_valid / rsp_dirty  out  1 / 1  state of the reported way
- rsp_tag  out  TAG_BIT  tag of the reported way
- rsp_data  out  LINE_W  line of the reported way

## Operation
- Per set, per way: {valid, dirty, tag[TAG_BIT]} and a line. Per set: NUM_WAYS ages of WAY_BIT bits each, always a permutation of 0..NUM_WAYS-1; age 0 = MRU.
- FSM: INIT → IDLE ↔ FLUSH. INIT and FLUSH are identical sweeps. Each visits sets 0..NUMBER_OF_SETS-1, one per cycle. Each visit clears valid/dirty in all ways and sets age[w]=w. Tags and data are left untouched. The last visit pulses sweep_done and returns to IDLE.
- req_ready = (state==IDLE) & ~flush_req. flush_req in IDLE moves to FLUSH next cycle. A flush_req outside IDLE is ignored.
- Stage register: an accepted request is captured with its reduced index. The next cycle, the arrays are read combinationally at that index. rsp_valid=1 and all rsp_* fields reflect the pre-op state. The op's writes occur at the end of that cycle. This gives one write port per array and no same-edge conflicts.
- LOOKUP hit: the way with valid & tag match; the lowest index wins if several match. Outputs are rsp_hit=1, that way's fields, and the way made MRU.
- LOOKUP miss: rsp_hit=0. The victim is the lowest-index invalid way; otherwise the way with age NUM_WAYS-1. The victim's fields are reported for write-back. Ages are unchanged.
- FILL writes tag/data to req_way with valid=1 and dirty=req_dirty, and makes req_way MRU. The reported fields are the old contents of req_way.
- WRITE writes data to req_way and sets dirty=1. Tag and valid are unchanged, with no tag check. req_way becomes MRU.
- INVALIDATE clears valid/dirty of req_way. Ages are unchanged.
- MRU update for way w with old age a: age[w]←0; every way with age < a gets age+1; the others are unchanged.
- When rsp_valid=0, the rsp_* fields hold their last values.

## Timing
- Reset: state=INIT, sweep counter=0, stage empty, busy=1, req_ready=0, rsp_valid=0, sweep_done=0, rsp_* all 0. The first sweep starts on the first clock after rst_n rises.
- busy = (state≠IDLE). INIT takes NUMBER_OF_SETS cycles. sweep_done is high on the cycle of the last visit; IDLE and req_ready=1 follow on the next cycle.
- Throughput is one request per cycle in IDLE. Latency is exactly 1: accept at edge T, rsp_valid high during T+1.
- Back-to-back same set: a request accepted at T+1 sees the writes of the request accepted at T.
- flush_req while a request sits in the stage: that response completes during the flush_req cycle, and FLUSH begins on the next cycle.
- req_index ≥ NUMBER_OF_SETS aliases to index % NUMBER_OF_SETS.
- rst_n low mid-sweep or mid-request aborts the operation. The block returns to the reset values and INIT restarts from set 0.

## Test plan
- Reset → INIT: release rst_n; busy=1 for exactly 1000 cycles and sweep_done pulses once. Then LOOKUP idx 5, tag 0x12345 → rsp_hit=0, rsp_way=0, rsp_line_valid=0.
- Fill/hit: FILL idx 7 way 1 tag 0xABCDE, data 0x…0003_0002_0001_0000, req_dirty=0 → one cycle later, LOOKUP tag 0xABCDE → hit, way 1, same data, rsp_dirty=0.
- LRU, NUM_WAYS=4: FILL ways 0,1,2,3 of idx 3, then LOOKUP hit on way 0, then LOOKUP miss → victim way 1, reporting its tag and data.
- Write-back: WRITE idx 3 way 1 new data → rsp_valid; a later miss selecting way 1 reports rsp_dirty=1 and the new data. FILL of way 1 reports the old dirty line.
- Aliasing/invalidate: FILL idx 1002 → LOOKUP idx 2 hits. INVALIDATE that way → the next LOOKUP misses with rsp_way equal to the invalidated way.
- Flush/reset: flush_req the same cycle as req_valid → req_ready=0, an in-flight response still delivered, and all prior hits miss after sweep_done. Pulse rst_n low mid-FLUSH → busy stays 1 and INIT runs 1000 cycles.
